// File: rtl/pix_stream_packer_pkg.sv
// pix_stream_packer_pkg: shared system-state codes, frame geometry defaults and sync marker.
// The PIX_CHECKSUM_EN macro adds the CKSUM packer state.
package pix_stream_packer_pkg;
  localparam logic [7:0] ST_WAIT     = 8'h01;
  localparam logic [7:0] ST_TRANSFER = 8'h02;
  localparam logic [7:0] ST_DISPLAY  = 8'h03;
  localparam int W_DEF         = 50;
  localparam int H_DEF         = 40;
  localparam int PIX_TOTAL_DEF = W_DEF * H_DEF;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  typedef enum logic [2:0] {
    P_IDLE,
    P_SYNC,
    P_B0,
    P_B1,
    P_B2,
`ifdef PIX_CHECKSUM_EN
    P_CKSUM,
`endif
    P_DONE
  } pk_state_e;
endpackage

// File: rtl/pix_stream_packer.sv
// pix_stream_packer: locks on a sync byte, unpacks 3 UART bytes into 2 RGB444 pixels, counts a frame.
// Define PIX_CHECKSUM_EN to check a trailing XOR byte after the payload and report frame_err.
module pix_stream_packer
  import pix_stream_packer_pkg::*;
#(
  parameter int         W         = W_DEF,
  parameter int         H         = H_DEF,
  parameter int         PIX_TOTAL = W * H,
  parameter logic [7:0] SYNC_BYTE = pix_stream_packer_pkg::SYNC_BYTE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  state,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        rx_valid,
  output logic [11:0] rx_data,
  output logic [14:0] pix_cnt,
  output logic        frame_done,
  output logic        frame_err
);
  if (PIX_TOTAL % 2 != 0) begin : g_odd
    $error("pix_stream_packer: PIX_TOTAL must be even");
  end
  localparam logic [14:0] LAST = 15'(PIX_TOTAL - 1);
  pk_state_e   st_q, st_d;
  logic [7:0]  hold_q, hold_d;
  logic        vld_q, vld_d;
  logic [11:0] data_q, data_d;
  logic [14:0] cnt_q, cnt_d;
  logic        done_q, done_d;
`ifdef PIX_CHECKSUM_EN
  logic [7:0]  xor_q, xor_d;
  logic        err_q, err_d;
  assign frame_err = err_q;
`else
  assign frame_err = 1'b0;
`endif
  assign rx_valid   = vld_q;
  assign rx_data    = data_q;
  assign pix_cnt    = cnt_q;
  assign frame_done = done_q;
  always_comb begin
    st_d   = st_q;
    hold_d = hold_q;
    vld_d  = 1'b0;
    data_d = data_q;
    cnt_d  = cnt_q;
    done_d = done_q;
`ifdef PIX_CHECKSUM_EN
    xor_d  = xor_q;
    err_d  = err_q;
`endif
    if (state != ST_TRANSFER) begin
      st_d   = P_IDLE;
      hold_d = '0;
      cnt_d  = '0;
      done_d = 1'b0;
`ifdef PIX_CHECKSUM_EN
      err_d  = 1'b0;
`endif
    end else begin
      case (st_q)
        P_IDLE: st_d = P_SYNC;
        P_SYNC: begin
`ifdef PIX_CHECKSUM_EN
          xor_d = '0;
`endif
          if (byte_valid && byte_data == SYNC_BYTE) st_d = P_B0;
        end
        P_B0: if (byte_valid) begin
          hold_d = byte_data;
          st_d   = P_B1;
        end
        // hold_q carries {R0,G0} into B1, then only R1 into B2
        P_B1: if (byte_valid) begin
          vld_d  = 1'b1;
          data_d = {hold_q, byte_data[7:4]};
          hold_d = {4'h0, byte_data[3:0]};
          cnt_d  = cnt_q + 15'd1;
          st_d   = P_B2;
        end
        P_B2: if (byte_valid) begin
          vld_d  = 1'b1;
          data_d = {hold_q[3:0], byte_data};
          cnt_d  = cnt_q + 15'd1;
          st_d   = P_B0;
          if (cnt_q == LAST) begin
`ifdef PIX_CHECKSUM_EN
            st_d   = P_CKSUM;
`else
            st_d   = P_DONE;
            done_d = 1'b1;
`endif
          end
        end
`ifdef PIX_CHECKSUM_EN
        P_CKSUM: if (byte_valid) begin
          done_d = byte_data == xor_q;
          err_d  = byte_data != xor_q;
          st_d   = P_DONE;
        end
`endif
        default: ;
      endcase
`ifdef PIX_CHECKSUM_EN
      if (byte_valid && (st_q == P_B0 || st_q == P_B1 || st_q == P_B2)) xor_d = xor_q ^ byte_data;
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= P_IDLE;
      hold_q <= '0;
      vld_q  <= 1'b0;
      data_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
`ifdef PIX_CHECKSUM_EN
      xor_q  <= '0;
      err_q  <= 1'b0;
`endif
    end else begin
      st_q   <= st_d;
      hold_q <= hold_d;
      vld_q  <= vld_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
`ifdef PIX_CHECKSUM_EN
      xor_q  <= xor_d;
      err_q  <= err_d;
`endif
    end
  end
endmodule

// File: tb/tb_pix_stream_packer.sv
// tb_pix_stream_packer: scoreboard bench for pix_stream_packer; PIX_CHECKSUM_EN selects a 2x1 frame with checksum tests.
module tb_pix_stream_packer;
  import pix_stream_packer_pkg::*;
`ifdef PIX_CHECKSUM_EN
  localparam int TW = 2, TH = 1;
`else
  localparam int TW = 50, TH = 40;
`endif
  localparam int TOT = TW * TH;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [7:0]  state = 8'h00;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        rx_valid, frame_done, frame_err;
  logic [11:0] rx_data, mon_exp;
  logic [14:0] pix_cnt;
  int checks = 0, failures = 0;
  logic [11:0] exp_q[$];
  always #5 clk = ~clk;
  pix_stream_packer #(.W(TW), .H(TH)) dut (
    .clk(clk), .rst_n(rst_n), .state(state), .byte_valid(byte_valid), .byte_data(byte_data),
    .rx_valid(rx_valid), .rx_data(rx_data), .pix_cnt(pix_cnt), .frame_done(frame_done), .frame_err(frame_err)
  );
  always @(negedge clk) if (rst_n && rx_valid) begin
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_pixel got=%h want=none", rx_data);
    end else begin
      mon_exp = exp_q.pop_front();
      if (rx_data !== mon_exp) begin
        failures++;
        $display("FAIL pixel_data got=%h want=%h", rx_data, mon_exp);
      end
    end
  end
  task automatic send(input logic [7:0] b, input logic emit, input logic [11:0] px);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    if (emit) exp_q.push_back(px);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
    checks++;
    if (rx_valid !== emit) begin
      failures++;
      $display("FAIL emit_timing byte=%h got=%b want=%b", b, rx_valid, emit);
    end
  endtask
  task automatic pair(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send(b0, 1'b0, 12'h0);
    send(b1, 1'b1, {b0, b1[7:4]});
    send(b2, 1'b1, {b1[3:0], b2});
  endtask
  task automatic enter_transfer();
    state = ST_TRANSFER;
    repeat (2) @(negedge clk);
  endtask
  task automatic leave_transfer();
    state = ST_WAIT;
    @(negedge clk);
  endtask
  task automatic check_cnt(input string name, input logic [14:0] want);
    checks++;
    if (pix_cnt !== want) begin
      failures++;
      $display("FAIL %s pix_cnt got=%0d want=%0d", name, pix_cnt, want);
    end
  endtask
  task automatic check_flags(input string name, input logic done, input logic err);
    checks++;
    if (frame_done !== done || frame_err !== err) begin
      failures++;
      $display("FAIL %s done/err got=%b%b want=%b%b", name, frame_done, frame_err, done, err);
    end
  endtask
  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s missing_pixels got=%0d want=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic test_reset();
    #1;
    checks++;
    if (rx_valid !== 1'b0 || rx_data !== 12'h0) begin
      failures++;
      $display("FAIL reset_rx got=%b/%h want=0/000", rx_valid, rx_data);
    end
    check_cnt("reset", 15'd0);
    check_flags("reset", 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_basic();
    enter_transfer();
    send(8'hA5, 1'b0, 12'h0);
    send(8'h12, 1'b0, 12'h0);
    send(8'h34, 1'b1, 12'h123);
    send(8'h56, 1'b1, 12'h456);
    check_cnt("basic", 15'd2);
    check_flags("basic", 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (rx_data !== 12'h456) begin
      failures++;
      $display("FAIL basic_hold rx_data got=%h want=456", rx_data);
    end
    leave_transfer();
    check_cnt("basic_leave", 15'd0);
    check_drained("basic");
  endtask
  task automatic test_sync_hunt();
    enter_transfer();
    send(8'h00, 1'b0, 12'h0);
    send(8'hFF, 1'b0, 12'h0);
    send(8'h5A, 1'b0, 12'h0);
    send(8'hA5, 1'b0, 12'h0);
    pair(8'hAB, 8'hCD, 8'hEF);
    check_cnt("sync_hunt", 15'd2);
    leave_transfer();
    check_drained("sync_hunt");
  endtask
  task automatic test_full_frame();
    enter_transfer();
    send(8'hA5, 1'b0, 12'h0);
    for (int i = 0; i < TOT / 2; i++) begin
      pair(i == 0 ? 8'hA5 : 8'($urandom), 8'($urandom), i == 5 ? 8'hA5 : 8'($urandom));
      if (i == TOT / 2 - 2) check_flags("pre_last", 1'b0, 1'b0);
    end
    check_flags("frame_done_rise", 1'b1, 1'b0);
    check_cnt("full_frame", 15'(TOT));
    for (int i = 0; i < 10; i++) send(i == 3 ? 8'hA5 : 8'($urandom), 1'b0, 12'h0);
    check_flags("after_trailing", 1'b1, 1'b0);
    check_cnt("after_trailing", 15'(TOT));
    leave_transfer();
    check_flags("full_leave", 1'b0, 1'b0);
    check_cnt("full_leave", 15'd0);
    check_drained("full_frame");
  endtask
  task automatic test_abort();
    logic [7:0] b0, b1;
    enter_transfer();
    send(8'hA5, 1'b0, 12'h0);
    for (int i = 0; i < 6; i++) pair(8'($urandom), 8'($urandom), 8'($urandom));
    b0 = 8'h9C;
    b1 = 8'h3E;
    send(b0, 1'b0, 12'h0);
    send(b1, 1'b1, {b0, b1[7:4]});
    check_cnt("abort_pre", 15'd13);
    state      = ST_WAIT;
    byte_valid = 1'b1;
    byte_data  = 8'h77;
    @(negedge clk);
    byte_valid = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_drop rx_valid got=%b want=0", rx_valid);
    end
    check_cnt("abort", 15'd0);
    enter_transfer();
    send(8'h77, 1'b0, 12'h0);
    send(8'h11, 1'b0, 12'h0);
    send(8'h22, 1'b0, 12'h0);
    send(8'h33, 1'b0, 12'h0);
    check_cnt("abort_resync_wait", 15'd0);
    send(8'hA5, 1'b0, 12'h0);
    pair(8'h1F, 8'h2E, 8'h3D);
    check_cnt("abort_resync", 15'd2);
    leave_transfer();
    check_drained("abort");
  endtask
  task automatic test_checksum();
    enter_transfer();
    send(8'hA5, 1'b0, 12'h0);
    pair(8'h12, 8'h34, 8'h56);
    check_flags("cksum_wait", 1'b0, 1'b0);
    send(8'h70, 1'b0, 12'h0);
    check_flags("cksum_ok", 1'b1, 1'b0);
    check_cnt("cksum_ok", 15'd2);
    leave_transfer();
    check_flags("cksum_leave", 1'b0, 1'b0);
    enter_transfer();
    send(8'hA5, 1'b0, 12'h0);
    pair(8'h12, 8'h34, 8'h56);
    send(8'h71, 1'b0, 12'h0);
    check_flags("cksum_bad", 1'b0, 1'b1);
    leave_transfer();
    check_flags("cksum_bad_leave", 1'b0, 1'b0);
    check_drained("checksum");
  endtask
  task automatic test_async_reset();
    enter_transfer();
    send(8'hA5, 1'b0, 12'h0);
    send(8'h12, 1'b0, 12'h0);
    send(8'h34, 1'b1, 12'h123);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset rx_valid got=%b want=0", rx_valid);
    end
    check_cnt("async_reset", 15'd0);
    check_flags("async_reset", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    leave_transfer();
    check_drained("async_reset");
  endtask
  initial begin
    test_reset();
    test_basic();
    test_sync_hunt();
`ifdef PIX_CHECKSUM_EN
    test_checksum();
`else
    test_full_frame();
    test_abort();
`endif
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pix_stream_packer.md
Name: pix_stream_packer

Overview:
- Producer side of the frame buffer's pixel write interface: turns the UART byte stream into single-cycle `rx_valid`/`rx_data` RGB444 pixel strobes.
- Sits between uart_rx and the frame buffer.
- Active only while the system state is TRANSFER (8'h02).
- Locks on a sync byte, unpacks 2 pixels per 3 bytes, counts pixels to a full frame, then flags completion.

Parameters:
- W, 50, image width in pixels
- H, 40, image height in pixels
- PIX_TOTAL, W*H, pixels per frame; must be even, otherwise an elaboration-time error is raised
- SYNC_BYTE, 8'hA5, frame start marker

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- state  in  8  system state; 8'h02 = TRANSFER
- byte_valid  in  1  one-cycle strobe from uart_rx
- byte_data  in  8  received byte, valid with byte_valid
- rx_valid  out  1  one-cycle pixel strobe to frame buffer
- rx_data  out  12  RGB444 pixel {R,G,B}, valid with rx_valid
- pix_cnt  out  15  pixels emitted this frame
- frame_done  out  1  level; full frame emitted
- frame_err  out  1  level; checksum mismatch (feature only, else tied 0)

Behaviour:
- Reset: all outputs 0; FSM in IDLE; internal holding nibbles cleared.
- FSM states: IDLE, SYNC, B0, B1, B2, CKSUM (feature only), DONE.
- Whenever state != 8'h02, next cycle:
  - FSM goes to IDLE;
  - pix_cnt, frame_done and frame_err clear;
  - any partial pixel is discarded.
  - This applies mid-frame too.
- IDLE: if state == 8'h02, go to SYNC.
- SYNC: bytes other than SYNC_BYTE are ignored. On SYNC_BYTE, go to B0.
- Byte packing:
  - byte0 = {R0,G0}
  - byte1 = {B0,R1}
  - byte2 = {G1,B1}
- B0: on byte, hold R0/G0, go to B1.
- B1: on byte:
  - emit pixel {R0,G0,B0};
  - hold R1;
  - go to B2.
- B2: on byte:
  - emit pixel {R1,G1,B1};
  - go to B0, or to DONE/CKSUM if pix_cnt reaches PIX_TOTAL.
- Emit latency:
  - rx_valid/rx_data are registered, asserted exactly 1 cycle after the causing byte_valid.
  - rx_valid is high for 1 cycle.
  - rx_data holds its value until the next emit.
- pix_cnt increments in the same cycle rx_valid asserts. It equals PIX_TOTAL after the last pixel.
- Terminal condition: when the emitted pixel makes pix_cnt == PIX_TOTAL, no further rx_valid is produced. Terminal is always in B2 because PIX_TOTAL is even.
- DONE:
  - frame_done = 1, rising together with the last rx_valid (without the feature);
  - extra bytes ignored;
  - stays until state leaves 8'h02.
- A SYNC_BYTE value inside the payload is data; no resync.
- byte_valid in the same cycle as a state change away from 8'h02: the byte is dropped.
- Reset assertion is asynchronous at any point: outputs clear immediately.

Optional Feature:
- Macro PIX_CHECKSUM_EN.
- Defined:
  - running XOR of all payload bytes; the sync byte is excluded;
  - after the last payload byte the FSM enters CKSUM;
  - the next byte is compared with the XOR;
  - on match, frame_done = 1 one cycle after that byte;
  - on mismatch, frame_err = 1, frame_done stays 0;
  - then DONE;
  - the XOR clears in SYNC.
- Undefined:
  - no CKSUM state;
  - frame_err constant 0;
  - frame_done as above.

Decomposition:
- Shared package holds:
  - state encodings ST_WAIT = 8'h01, ST_TRANSFER = 8'h02, ST_DISPLAY = 8'h03;
  - W, H, PIX_TOTAL defaults;
  - SYNC_BYTE.
- The frame buffer and this block import these values instead of literals.
- No sub-module is natural; the checksum is a single XOR register inside an ifdef.

Test Plan:
- Basic unpack, with state = 8'h02:
  - stimulus: send A5, 12, 34, 56;
  - rx_valid pulses rx_data = 123 one cycle after the 34 byte;
  - then rx_data = 456 one cycle after the 56 byte;
  - pix_cnt = 2.
- Sync hunt: send 00, FF, 5A, then A5, AB, CD, EF → exactly two pixels, ABC and DEF; no pixel from the preceding garbage.
- Full frame:
  - stimulus: A5 followed by 3000 bytes;
  - 2000 rx_valid pulses; frame_done rises with the 2000th; pix_cnt = 2000;
  - 10 trailing bytes produce no rx_valid.
- Abort: drop state to 8'h01 after byte1 of pixel pair 7 → next cycle pix_cnt = 0, no pixel emitted; returning to 8'h02 requires a new A5.
- Async reset mid-frame: assert rst_n low between clock edges → rx_valid, pix_cnt, frame_done read 0 before the next edge.
- PIX_CHECKSUM_EN:
  - W = 2, H = 1, stimulus A5, 12, 34, 56, 70: XOR of 12, 34, 56 is 70, so frame_done = 1;
  - repeat with a final byte of 71 → frame_err = 1, frame_done = 0.
